// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: grants the single register-file write port to either the
// ALU result or a load return, MEM first, with a starvation guard for the ALU.
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_alu_valid,
    output logic        o_alu_ready,
    input  logic [63:0] i_alu_data,
    input  logic [4:0]  i_alu_rd,
    input  logic        i_mem_valid,
    output logic        o_mem_ready,
    input  logic [63:0] i_mem_data,
    input  logic [4:0]  i_mem_rd,
    output logic        o_rf_we,
    output logic [4:0]  o_rf_waddr,
    output logic [63:0] o_rf_wdata,
    output logic        o_mem_to_reg
);

    localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [4:0]       LP_XZR   = 5'd31;

    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_rf_we;
    logic [4:0]       r_rf_waddr;
    logic [63:0]      r_rf_wdata;
    logic             r_mem_to_reg;

    logic             w_force_alu;
    logic             w_alu_ready;
    logic             w_mem_ready;
    logic             w_alu_hs;
    logic             w_mem_hs;
    logic [CNT_W-1:0] w_starve_nxt;
    logic             w_we_nxt;
    logic [4:0]       w_waddr_nxt;
    logic [63:0]      w_wdata_nxt;
    logic             w_m2r_nxt;

    // Grant decision: MEM wins a conflict unless the ALU has been held off long enough.
    always_comb begin
        w_force_alu = (r_starve_cnt == LP_LIMIT);
        w_alu_ready = 1'b0;
        w_mem_ready = 1'b0;
        if (i_reset) begin
            w_alu_ready = 1'b0;
            w_mem_ready = 1'b0;
        end else begin
            w_mem_ready = i_mem_valid & ~(w_force_alu & i_alu_valid);
            w_alu_ready = i_alu_valid & (~i_mem_valid | w_force_alu);
        end
        w_alu_hs = i_alu_valid & w_alu_ready;
        w_mem_hs = i_mem_valid & w_mem_ready;
    end

    // Next starve count: any cycle the ALU is not waiting, or gets through, restarts it.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!i_alu_valid || w_alu_hs) begin
            w_starve_nxt = {CNT_W{1'b0}};
        end else if (r_starve_cnt != LP_LIMIT) begin
            w_starve_nxt = r_starve_cnt + CNT_W'(1);
        end else begin
            w_starve_nxt = r_starve_cnt;
        end
    end

    // Next writeback beat; XZR destinations still consume the grant but never write.
    always_comb begin
        w_we_nxt    = 1'b0;
        w_waddr_nxt = 5'd0;
        w_wdata_nxt = 64'd0;
        w_m2r_nxt   = 1'b0;
        if (w_mem_hs) begin
            w_we_nxt    = (i_mem_rd != LP_XZR);
            w_waddr_nxt = i_mem_rd;
            w_wdata_nxt = i_mem_data;
            w_m2r_nxt   = 1'b1;
        end else if (w_alu_hs) begin
            w_we_nxt    = (i_alu_rd != LP_XZR);
            w_waddr_nxt = i_alu_rd;
            w_wdata_nxt = i_alu_data;
            w_m2r_nxt   = 1'b0;
        end else begin
            w_we_nxt    = 1'b0;
            w_waddr_nxt = 5'd0;
            w_wdata_nxt = 64'd0;
            w_m2r_nxt   = 1'b0;
        end
    end

    // Output register stage and starve counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_starve_cnt <= {CNT_W{1'b0}};
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= 5'd0;
            r_rf_wdata   <= 64'd0;
            r_mem_to_reg <= 1'b0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
            r_rf_we      <= w_we_nxt;
            r_rf_waddr   <= w_waddr_nxt;
            r_rf_wdata   <= w_wdata_nxt;
            r_mem_to_reg <= w_m2r_nxt;
        end
    end

    assign o_alu_ready  = w_alu_ready;
    assign o_mem_ready  = w_mem_ready;
    assign o_rf_we      = r_rf_we;
    assign o_rf_waddr   = r_rf_waddr;
    assign o_rf_wdata   = r_rf_wdata;
    assign o_mem_to_reg = r_mem_to_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus a randomized run
// scored against a grant/starvation model kept in the bench.
module tb_wb_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [63:0] alu_data, mem_data, rf_wdata;
    logic [4:0]  alu_rd, mem_rd, rf_waddr;
    logic        rf_we, mem_to_reg;

    int errors = 0;
    int checks = 0;

    logic        a_r, m_r, we, m2r;
    logic [4:0]  wa;
    logic [63:0] wd;

    always #5 clk = ~clk;

    wb_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_alu_valid(alu_valid), .o_alu_ready(alu_ready), .i_alu_data(alu_data), .i_alu_rd(alu_rd),
        .i_mem_valid(mem_valid), .o_mem_ready(mem_ready), .i_mem_data(mem_data), .i_mem_rd(mem_rd),
        .o_rf_we(rf_we), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata), .o_mem_to_reg(mem_to_reg)
    );

    // Inputs are set at a falling edge; sample readies, clock once, sample the registered beat.
    task automatic tick();
        #1;
        a_r = alu_ready;
        m_r = mem_ready;
        @(posedge clk);
        #1;
        we  = rf_we;
        wa  = rf_waddr;
        wd  = rf_wdata;
        m2r = mem_to_reg;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'h1111;
        mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 64'h2222;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (a_r !== 1'b0) begin errors++; $display("FAIL reset_alu_ready cyc%0d got=%b exp=0", i, a_r); end
            checks++; if (m_r !== 1'b0) begin errors++; $display("FAIL reset_mem_ready cyc%0d got=%b exp=0", i, m_r); end
            checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_rf_we cyc%0d got=%b exp=0", i, we); end
            checks++; if (m2r !== 1'b0) begin errors++; $display("FAIL reset_mem_to_reg cyc%0d got=%b exp=0", i, m2r); end
            checks++; if (wd !== 64'd0) begin errors++; $display("FAIL reset_rf_wdata cyc%0d got=%h exp=0", i, wd); end
        end
        alu_valid = 1'b0; mem_valid = 1'b0; reset = 1'b0;
        tick();
    endtask

    task automatic test_alu_only();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        mem_valid = 1'b0;
        tick();
        checks++; if (a_r !== 1'b1) begin errors++; $display("FAIL alu_only_ready got=%b exp=1", a_r); end
        checks++; if (m_r !== 1'b0) begin errors++; $display("FAIL alu_only_mem_ready got=%b exp=0", m_r); end
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL alu_only_we got=%b exp=1", we); end
        checks++; if (wa !== 5'd5) begin errors++; $display("FAIL alu_only_waddr got=%0d exp=5", wa); end
        checks++; if (wd !== 64'h1234) begin errors++; $display("FAIL alu_only_wdata got=%h exp=1234", wd); end
        checks++; if (m2r !== 1'b0) begin errors++; $display("FAIL alu_only_m2r got=%b exp=0", m2r); end
        alu_valid = 1'b0;
        tick();
        checks++; if (we !== 1'b0 || wd !== 64'd0 || wa !== 5'd0) begin
            errors++; $display("FAIL idle_beat got we=%b wa=%0d wd=%h exp we=0 wa=0 wd=0", we, wa, wd);
        end
    endtask

    task automatic test_conflict();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h55;
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 64'hAA;
        tick();
        checks++; if (m_r !== 1'b1 || a_r !== 1'b0) begin errors++; $display("FAIL conflict_ready got m=%b a=%b exp m=1 a=0", m_r, a_r); end
        checks++; if (m2r !== 1'b1) begin errors++; $display("FAIL conflict_m2r got=%b exp=1", m2r); end
        checks++; if (wa !== 5'd3) begin errors++; $display("FAIL conflict_waddr got=%0d exp=3", wa); end
        checks++; if (wd !== 64'hAA) begin errors++; $display("FAIL conflict_wdata got=%h exp=aa", wd); end
        mem_valid = 1'b0;
        tick();
        checks++; if (a_r !== 1'b1 || wa !== 5'd7 || m2r !== 1'b0) begin
            errors++; $display("FAIL conflict_alu_follow got a=%b wa=%0d m2r=%b exp a=1 wa=7 m2r=0", a_r, wa, m2r);
        end
        alu_valid = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        int mi;
        logic exp_alu;
        mi = 0;
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 64'hC0DE;
        mem_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            mem_rd = 5'(1 + mi); mem_data = 64'hB000 + 64'(mi);
            exp_alu = (k == LIMIT);
            tick();
            checks++; if (a_r !== exp_alu || m_r !== !exp_alu) begin
                errors++; $display("FAIL starve_grant cyc%0d got a=%b m=%b exp a=%b m=%b", k, a_r, m_r, exp_alu, !exp_alu);
            end
            checks++; if (we !== 1'b1) begin errors++; $display("FAIL starve_we cyc%0d got=%b exp=1", k, we); end
            if (exp_alu) begin
                checks++; if (wa !== 5'd12 || wd !== 64'hC0DE || m2r !== 1'b0) begin
                    errors++; $display("FAIL starve_alu_beat cyc%0d got wa=%0d wd=%h m2r=%b exp wa=12 wd=c0de m2r=0", k, wa, wd, m2r);
                end
            end else begin
                checks++; if (wa !== 5'(1 + mi) || wd !== 64'hB000 + 64'(mi) || m2r !== 1'b1) begin
                    errors++; $display("FAIL starve_mem_beat cyc%0d got wa=%0d wd=%h m2r=%b exp wa=%0d m2r=1", k, wa, wd, m2r, 1 + mi);
                end
                mi++;
            end
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL starve_drain_we got=%b exp=0", we); end
    endtask

    task automatic test_xzr();
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd31; mem_data = 64'hDEAD;
        tick();
        checks++; if (m_r !== 1'b1) begin errors++; $display("FAIL xzr_ready got=%b exp=1", m_r); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL xzr_we got=%b exp=0", we); end
        mem_valid = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        logic exp_alu;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h9999;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'h2;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (m_r !== 1'b1) begin errors++; $display("FAIL midrst_pre cyc%0d got m=%b exp=1", k, m_r); end
        end
        mem_valid = 1'b0; reset = 1'b1;
        tick();
        checks++; if (a_r !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b exp=0", a_r); end
        checks++; if (we !== 1'b0 || m2r !== 1'b0 || wd !== 64'd0) begin
            errors++; $display("FAIL midrst_out got we=%b m2r=%b wd=%h exp all 0", we, m2r, wd);
        end
        reset = 1'b0; mem_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_alu = (k == LIMIT);
            tick();
            checks++; if (a_r !== exp_alu || m2r !== !exp_alu) begin
                errors++; $display("FAIL midrst_cnt_clear cyc%0d got a=%b m2r=%b exp a=%b m2r=%b", k, a_r, m2r, exp_alu, !exp_alu);
            end
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();
    endtask

    // Randomized sources that hold each beat until accepted, scored against a winner model.
    task automatic test_random();
        int          blocked;
        int          win;
        logic        e_we, e_m2r;
        logic [4:0]  e_wa;
        logic [63:0] e_wd;
        blocked = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            if (!alu_valid) begin
                alu_valid = ($urandom_range(0, 2) != 0);
                alu_data  = {$urandom, $urandom};
                alu_rd    = 5'($urandom_range(0, 31));
            end
            if (!mem_valid) begin
                mem_valid = ($urandom_range(0, 3) != 0);
                mem_data  = {$urandom, $urandom};
                mem_rd    = 5'($urandom_range(0, 31));
            end
            if (reset) win = 0;
            else if (alu_valid && mem_valid) win = (blocked >= LIMIT) ? 1 : 2;
            else if (alu_valid) win = 1;
            else if (mem_valid) win = 2;
            else win = 0;
            e_we = 1'b0; e_wa = 5'd0; e_wd = 64'd0; e_m2r = 1'b0;
            if (win == 1) begin e_we = (alu_rd != 5'd31); e_wa = alu_rd; e_wd = alu_data; end
            if (win == 2) begin e_we = (mem_rd != 5'd31); e_wa = mem_rd; e_wd = mem_data; e_m2r = 1'b1; end
            if (reset) blocked = 0;
            else if (alu_valid && win != 1) blocked = (blocked + 1 > LIMIT) ? LIMIT : blocked + 1;
            else blocked = 0;
            tick();
            checks++; if (a_r !== (win == 1) || m_r !== (win == 2)) begin
                errors++; $display("FAIL rand_ready cyc%0d got a=%b m=%b exp a=%b m=%b", c, a_r, m_r, win == 1, win == 2);
            end
            checks++; if (we !== e_we || m2r !== e_m2r) begin
                errors++; $display("FAIL rand_ctrl cyc%0d got we=%b m2r=%b exp we=%b m2r=%b", c, we, m2r, e_we, e_m2r);
            end
            checks++; if (wa !== e_wa || wd !== e_wd) begin
                errors++; $display("FAIL rand_beat cyc%0d got wa=%0d wd=%h exp wa=%0d wd=%h", c, wa, wd, e_wa, e_wd);
            end
            if (win == 1) alu_valid = 1'b0;
            if (win == 2) mem_valid = 1'b0;
        end
        reset = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        alu_valid = 1'b0; alu_data = 64'd0; alu_rd = 5'd0;
        mem_valid = 1'b0; mem_data = 64'd0; mem_rd = 5'd0;
        @(negedge clk);
        test_reset();
        test_alu_only();
        test_conflict();
        test_starvation();
        test_xzr();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
